// File: rtl/keypad_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | keypad_pkg : shared types, constants and row decode for the 4x4     |
// | keypad scanner.                            Revision: 1.0            |
// +--------------------------------------------------------------------+
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } scan_state_t;

    localparam logic [3:0] KC_RESET = 4'b1110;

    // Returns {valid, multi, row[1:0]} for one column's active-low row return.
    function automatic logic [3:0] row_code(input logic [3:0] kr);
        logic [3:0] res;
        res = 4'b0000;
        case (kr)
            4'b1111: res = 4'b0000;
            4'b1110: res = 4'b1000;
            4'b1101: res = 4'b1001;
            4'b1011: res = 4'b1010;
            4'b0111: res = 4'b1011;
            default: res = 4'b0100;
        endcase
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | keypad_if : keypad matrix lines and debounced key outputs.         |
// |                                            Revision: 1.0            |
// +--------------------------------------------------------------------+
interface keypad_if;
    logic [3:0] kr;
    logic [3:0] kc;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_held;

    modport master (input kr, output kc, key_valid, key_code, key_held);
    modport slave  (output kr, input kc, key_valid, key_code, key_held);
endinterface
`default_nettype wire

// File: rtl/keypad_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | keypad_debounce : scan-rate press/release debounce FSM and key      |
// | outputs.                                   Revision: 1.0            |
// +--------------------------------------------------------------------+
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scan_done,
    input  logic       scan_hit,
    input  logic [3:0] scan_code,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_held
);

    localparam int              CW      = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_SCANS);

    scan_state_t   state_q, state_d;
    logic [3:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          valid_q, valid_d;
    logic [3:0]    code_q, code_d;
    logic          held_q, held_d;
    logic [CW-1:0] w_cnt_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cand_q  <= 4'h0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            code_q  <= 4'h0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            code_q  <= code_d;
            held_q  <= held_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        valid_d   = 1'b0;
        code_d    = code_q;
        held_d    = held_q;
        w_cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
        if (scan_done) begin
            case (state_q)
                IDLE: begin
                    if (scan_hit) begin
                        state_d = DEBOUNCE;
                        cand_d  = scan_code;
                        cnt_d   = CW'(1);
                    end
                end
                DEBOUNCE: begin
                    if (!scan_hit) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (scan_code == cand_q) begin
                        cnt_d = w_cnt_inc;
                        if (w_cnt_inc == CNT_MAX) begin
                            state_d = PRESSED;
                            code_d  = cand_q;
                            held_d  = 1'b1;
                            valid_d = 1'b1;
                        end
                    end else begin
                        cand_d = scan_code;
                        cnt_d  = CW'(1);
                    end
                end
                PRESSED: begin
                    if (!(scan_hit && scan_code == cand_q)) begin
                        state_d = RELEASE;
                        cnt_d   = scan_hit ? '0 : CW'(1);
                    end
                end
                RELEASE: begin
                    // A different key only restarts the release count; it cannot be accepted yet.
                    if (!scan_hit) begin
                        cnt_d = w_cnt_inc;
                        if (w_cnt_inc == CNT_MAX) begin
                            state_d = IDLE;
                            held_d  = 1'b0;
                            cnt_d   = '0;
                        end
                    end else if (scan_code == cand_q) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign key_valid = valid_q;
    assign key_code  = code_q;
    assign key_held  = held_q;

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | keypad_scanner : column strobe, per-scan hit accumulation with      |
// | ghost rejection, feeding the debounce FSM. Revision: 1.0            |
// +--------------------------------------------------------------------+
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int CLK_DIV        = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    keypad_if.master bus
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    col_q, col_d;
    logic [1:0]    hits_q, hits_d;
    logic          bad_q, bad_d;
    logic [3:0]    code_q, code_d;

    logic          w_tick;
    logic [3:0]    w_rc;
    logic [1:0]    w_hits;
    logic          w_bad;
    logic [3:0]    w_code;
    logic          w_scan_done;
    logic          w_scan_hit;
    logic [7:0]    w_kc_rot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            col_q   <= 2'd0;
            hits_q  <= 2'd0;
            bad_q   <= 1'b0;
            code_q  <= 4'h0;
        end else begin
            presc_q <= presc_d;
            col_q   <= col_d;
            hits_q  <= hits_d;
            bad_q   <= bad_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        presc_d = presc_q;
        col_d   = col_q;
        hits_d  = hits_q;
        bad_d   = bad_q;
        code_d  = code_q;
        w_tick  = (presc_q == PW'(CLK_DIV - 1));
        w_rc    = row_code(bus.kr);
        // Accumulated view including the column being sampled now; hits saturate at 2.
        w_hits  = hits_q;
        w_bad   = bad_q | w_rc[2];
        w_code  = code_q;
        if (w_rc[3]) begin
            w_hits = (hits_q == 2'd2) ? 2'd2 : hits_q + 2'd1;
            w_code = {w_rc[1:0], col_q};
        end
        if (w_tick) begin
            presc_d = '0;
            col_d   = col_q + 2'd1;
            if (col_q == 2'd3) begin
                hits_d = 2'd0;
                bad_d  = 1'b0;
                code_d = 4'h0;
            end else begin
                hits_d = w_hits;
                bad_d  = w_bad;
                code_d = w_code;
            end
        end else begin
            presc_d = presc_q + PW'(1);
        end
        w_scan_done = w_tick && (col_q == 2'd3);
        w_scan_hit  = (w_hits == 2'd1) && !w_bad;
    end

    assign w_kc_rot = {KC_RESET, KC_RESET} << col_q;
    assign bus.kc   = w_kc_rot[7:4];

    keypad_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
        .clk       (clk),
        .rst_n     (rst_n),
        .scan_done (w_scan_done),
        .scan_hit  (w_scan_hit),
        .scan_code (w_code),
        .key_valid (bus.key_valid),
        .key_code  (bus.key_code),
        .key_held  (bus.key_held)
    );

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_keypad_scanner : scan-aligned keypad stimulus against a          |
// | scan-level reference model.                Revision: 1.0            |
// +--------------------------------------------------------------------+
module tb_keypad_scanner;

    localparam int CLK_DIV = 4;
    localparam int DS      = 3;
    localparam int SCAN    = 4 * CLK_DIV;

    localparam logic [15:0] NK = 16'h0000;
    localparam logic [15:0] K0 = 16'h0001;
    localparam logic [15:0] K3 = 16'h0008;
    localparam logic [15:0] K4 = 16'h0010;
    localparam logic [15:0] K5 = 16'h0020;
    localparam logic [15:0] K6 = 16'h0040;
    localparam logic [15:0] K9 = 16'h0200;
    localparam logic [15:0] KA = 16'h0400;
    localparam logic [15:0] KF = 16'h8000;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    keypad_if kif ();

    keypad_scanner #(
        .CLK_DIV        (CLK_DIV),
        .DEBOUNCE_SCANS (DS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (kif)
    );

    // Keypad matrix: a pressed key (row k/4, col k%4) grounds its row while its column is driven low.
    logic [15:0] keys = 16'h0000;
    logic [3:0]  kr_drv;
    always_comb begin
        kr_drv = 4'hF;
        for (int k = 0; k < 16; k++)
            if (keys[k] && kif.kc[k % 4] == 1'b0) kr_drv[k / 4] = 1'b0;
    end
    assign kif.kr = kr_drv;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state at scan granularity.
    bit         m_held;
    logic [3:0] m_code;
    logic [3:0] m_cand;
    int         m_run;
    int         m_rel;
    bit         exp_pulse;

    int         obs_pulses;
    logic       obs_last;
    logic [3:0] obs_code;
    logic       obs_held;

    function automatic void model_reset();
        m_held = 1'b0; m_code = 4'h0; m_cand = 4'h0; m_run = 0; m_rel = 0; exp_pulse = 1'b0;
    endfunction

    // A scan reads as one key only when exactly one key is down; anything else reads as nothing.
    function automatic void model_scan(input logic [15:0] mask);
        bit         hit;
        logic [3:0] c;
        hit = ($countones(mask) == 1);
        c   = 4'h0;
        for (int k = 0; k < 16; k++) if (mask[k]) c = 4'(k);
        exp_pulse = 1'b0;
        if (!m_held) begin
            if (hit) begin
                if (m_run > 0 && c == m_cand) m_run++;
                else begin m_cand = c; m_run = 1; end
                if (m_run == DS) begin
                    m_held = 1'b1; m_code = c; exp_pulse = 1'b1; m_rel = 0;
                end
            end else begin
                m_run = 0;
            end
        end else begin
            if (hit) m_rel = 0;
            else begin
                m_rel++;
                if (m_rel == DS) begin m_held = 1'b0; m_run = 0; end
            end
        end
    endfunction

    task automatic do_scan(input logic [15:0] mask);
        keys       = mask;
        obs_pulses = 0;
        for (int j = 1; j <= SCAN; j++) begin
            @(posedge clk); #1;
            if (kif.key_valid === 1'b1) obs_pulses++;
        end
        obs_last = kif.key_valid;
        obs_code = kif.key_code;
        obs_held = kif.key_held;
        model_scan(mask);
    endtask

    task automatic test_reset();
        logic [3:0] exp_kc;
        #1 rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (kif.kc !== 4'b1110 || kif.key_valid !== 1'b0 || kif.key_code !== 4'h0 || kif.key_held !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_values: kc=%b valid=%b code=%h held=%b, required kc=1110 valid=0 code=0 held=0",
                     kif.kc, kif.key_valid, kif.key_code, kif.key_held);
        end
        @(negedge clk) rst_n = 1'b1;
        keys = NK;
        for (int j = 1; j <= 2 * SCAN; j++) begin
            @(posedge clk); #1;
            exp_kc = ~(4'b0001 << ((j / CLK_DIV) % 4));
            vectors++;
            if (kif.kc !== exp_kc || kif.key_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL idle_kc cycle %0d: kc=%b valid=%b, required kc=%b valid=0", j, kif.kc, kif.key_valid, exp_kc);
            end
            if (j % SCAN == 0) model_scan(NK);
        end
    endtask

    task automatic test_press_6();
        logic [15:0] seq [8];
        int total;
        seq   = '{K6, K6, K6, K6, NK, NK, NK, NK};
        total = 0;
        for (int i = 0; i < 8; i++) begin
            do_scan(seq[i]);
            total += obs_pulses;
            vectors++;
            if (obs_pulses !== (exp_pulse ? 1 : 0) || obs_last !== exp_pulse || obs_code !== m_code || obs_held !== m_held) begin
                miscompares++;
                $display("FAIL press6 scan %0d: pulses=%0d code=%h held=%b, required pulses=%0d code=%h held=%b",
                         i, obs_pulses, obs_code, obs_held, exp_pulse, m_code, m_held);
            end
            if (i == 3) begin
                vectors++;
                if (obs_code !== 4'h6 || obs_held !== 1'b1) begin
                    miscompares++;
                    $display("FAIL press6_code: code=%h held=%b, required code=6 held=1", obs_code, obs_held);
                end
            end
        end
        vectors++;
        if (total !== 1) begin
            miscompares++;
            $display("FAIL press6_pulse_count: pulses=%0d, required 1", total);
        end
    endtask

    task automatic test_bounce_9();
        logic [15:0] seq [9];
        seq = '{K9, K9, NK, K9, K9, K9, NK, NK, NK};
        for (int i = 0; i < 9; i++) begin
            do_scan(seq[i]);
            vectors++;
            if (obs_pulses !== (exp_pulse ? 1 : 0) || obs_last !== exp_pulse || obs_code !== m_code || obs_held !== m_held) begin
                miscompares++;
                $display("FAIL bounce9 scan %0d: pulses=%0d code=%h held=%b, required pulses=%0d code=%h held=%b",
                         i, obs_pulses, obs_code, obs_held, exp_pulse, m_code, m_held);
            end
        end
    endtask

    task automatic test_ghosting();
        logic [15:0] seq [12];
        seq = '{K0|K5, K0|K5, K0|K5, K0|K5, K0|K4, K0|K4, K0|K4, K0|K4,
                K0|K4|K9, K0|K4|K9, K0|K4|K9, K0|K4|K9};
        for (int i = 0; i < 12; i++) begin
            do_scan(seq[i]);
            vectors++;
            if (obs_pulses !== 0 || obs_code !== 4'h9 || obs_held !== 1'b0) begin
                miscompares++;
                $display("FAIL ghost scan %0d: pulses=%0d code=%h held=%b, required pulses=0 code=9 held=0",
                         i, obs_pulses, obs_code, obs_held);
            end
        end
    endtask

    task automatic test_reconfirm_f();
        logic [15:0] seq [17];
        int total;
        seq   = '{KF, KF, KF, KF, NK, KF, NK, K3, K3, K3, NK, NK, NK, K3, K3, K3, NK};
        total = 0;
        for (int i = 0; i < 17; i++) begin
            do_scan(seq[i]);
            total += obs_pulses;
            vectors++;
            if (obs_pulses !== (exp_pulse ? 1 : 0) || obs_last !== exp_pulse || obs_code !== m_code || obs_held !== m_held) begin
                miscompares++;
                $display("FAIL reconfirm scan %0d: pulses=%0d code=%h held=%b, required pulses=%0d code=%h held=%b",
                         i, obs_pulses, obs_code, obs_held, exp_pulse, m_code, m_held);
            end
        end
        vectors++;
        if (total !== 2) begin
            miscompares++;
            $display("FAIL reconfirm_pulse_count: pulses=%0d, required 2", total);
        end
        for (int i = 0; i < DS; i++) do_scan(NK);
    endtask

    task automatic test_random();
        logic [15:0] mask;
        int kind, len;
        for (int s = 0; s < 30; s++) begin
            kind = $urandom_range(0, 4);
            case (kind)
                0:       mask = NK;
                3:       mask = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
                default: mask = 16'h0001 << $urandom_range(0, 15);
            endcase
            len = $urandom_range(1, 5);
            for (int r = 0; r < len; r++) begin
                do_scan(mask);
                vectors++;
                if (obs_pulses !== (exp_pulse ? 1 : 0) || obs_last !== exp_pulse || obs_code !== m_code || obs_held !== m_held) begin
                    miscompares++;
                    $display("FAIL random seg %0d mask=%h: pulses=%0d code=%h held=%b, required pulses=%0d code=%h held=%b",
                             s, mask, obs_pulses, obs_code, obs_held, exp_pulse, m_code, m_held);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_scan(KA);
        do_scan(KA);
        keys = KA;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        vectors++;
        if (kif.kc !== 4'b1110 || kif.key_valid !== 1'b0 || kif.key_code !== 4'h0 || kif.key_held !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: kc=%b valid=%b code=%h held=%b, required kc=1110 valid=0 code=0 held=0",
                     kif.kc, kif.key_valid, kif.key_code, kif.key_held);
        end
        @(posedge clk); #1;
        vectors++;
        if (kif.kc !== 4'b1110 || kif.key_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_hold: kc=%b valid=%b, required kc=1110 valid=0", kif.kc, kif.key_valid);
        end
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_scan(KA);
            vectors++;
            if (obs_pulses !== (exp_pulse ? 1 : 0) || obs_last !== exp_pulse || obs_code !== m_code || obs_held !== m_held) begin
                miscompares++;
                $display("FAIL reset_mid scan %0d: pulses=%0d code=%h held=%b, required pulses=%0d code=%h held=%b",
                         i, obs_pulses, obs_code, obs_held, exp_pulse, m_code, m_held);
            end
        end
        vectors++;
        if (obs_code !== 4'hA || obs_held !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_code: code=%h held=%b, required code=a held=1", obs_code, obs_held);
        end
    endtask

    initial begin
        test_reset();
        test_press_6();
        test_bounce_9();
        test_ghosting();
        test_reconfirm_f();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
